// File: rtl/tri_lcb_seq_pkg.sv
// tri_lcb_seq_pkg: shared types for the latch-group hold/reset sequencer.
// Holds the sequencer state encoding (IDLE=0 .. HOLD=4).
package tri_lcb_seq_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/tri_lcb_seq_cnt.sv
// tri_lcb_seq_cnt: loadable down-counter that saturates at zero.
// Ports:
//   clk, rst_b  - clock, asynchronous active-low reset
//   load        - load load_val this cycle (has priority over counting)
//   load_val    - value to load
//   zero_c      - combinational flag, current count is zero
module tri_lcb_seq_cnt #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero_c
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: load, else decrement until zero and stay there
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/tri_lcb_seq.sv
// tri_lcb_seq: hold/reset sequencer for a bank of latch groups.
// A start request runs an INIT_CYCLES sreset pulse, then releases group holds
// one group every STAGGER cycles from group 0 upward; a stop request
// re-asserts holds from the highest released group downward.
// Ports:
//   clk, rst_b  - clock, asynchronous active-low reset
//   start_req   - pulse, begin init + staged release
//   stop_req    - pulse, begin staged hold
//   act_in      - per-group functional act
//   d1clk       - act to each group (gated by its release, combinational)
//   d2clk       - thold_b to each group, 1 = released (registered)
//   sreset      - init-load strobe to each group (registered)
//   start_ack   - pulse, all groups released
//   stop_ack    - pulse, all groups held
//   running     - all groups released
//   busy        - sequence in progress (not IDLE and not RUN)
module tri_lcb_seq
    import tri_lcb_seq_pkg::*;
#(
    parameter int unsigned GROUPS      = 4,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic [GROUPS-1:0] act_in,
    output logic [GROUPS-1:0] d1clk,
    output logic [GROUPS-1:0] d2clk,
    output logic [GROUPS-1:0] sreset,
    output logic              start_ack,
    output logic              stop_ack,
    output logic              running,
    output logic              busy
);

    localparam logic [CNT_WIDTH-1:0] INIT_LOAD    = CNT_WIDTH'(INIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STAGGER_LOAD = CNT_WIDTH'(STAGGER - 1);
    localparam logic [GROUPS-1:0]    MASK_ALL     = '1;
    localparam logic [GROUPS-1:0]    MASK_LSB     = GROUPS'(1);

    seq_state_e           state_q, state_d;
    logic [GROUPS-1:0]    mask_q, mask_d;
    logic [GROUPS-1:0]    sreset_q, sreset_d;
    logic                 start_ack_q, start_ack_d;
    logic                 stop_ack_q, stop_ack_d;
    logic                 running_q, running_d;
    logic                 busy_q, busy_d;
    logic                 pend_q, pend_d;

    logic                 cnt_load;
    logic [CNT_WIDTH-1:0] cnt_val;
    logic                 cnt_zero;

    // Shared counter: INIT length, then spacing between group steps
    tri_lcb_seq_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero_c   (cnt_zero)
    );

    // Next state, release mask and registered-output values
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pend_d      = pend_q;
        sreset_d    = '0;
        start_ack_d = 1'b0;
        stop_ack_d  = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = '0;

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                // Stop wins over a simultaneous start
                if (stop_req) begin
                    stop_ack_d = 1'b1;
                end else if (start_req) begin
                    state_d  = ST_INIT;
                    cnt_load = 1'b1;
                    cnt_val  = INIT_LOAD;
                end
            end

            ST_INIT: begin
                sreset_d = MASK_ALL;
                pend_d   = pend_q | stop_req;
                // Counter is already zero on exit, so the next state's first step is immediate
                if (cnt_zero) begin
                    state_d = pend_d ? ST_HOLD : ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (stop_req) begin
                    // Hold begins next cycle from whatever is released now
                    pend_d   = 1'b1;
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end else if (cnt_zero) begin
                    mask_d   = (mask_q << 1) | MASK_LSB;
                    cnt_load = 1'b1;
                    cnt_val  = STAGGER_LOAD;
                    if (mask_d == MASK_ALL) begin
                        start_ack_d = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (stop_req) begin
                    pend_d   = 1'b1;
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end
            end

            ST_HOLD: begin
                // Drop the highest released group; an empty mask ends the stop
                if (cnt_zero) begin
                    mask_d = mask_q >> 1;
                    if (mask_d == '0) begin
                        stop_ack_d = 1'b1;
                        pend_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = STAGGER_LOAD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        endcase

        running_d = (mask_d == MASK_ALL);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            sreset_q    <= '0;
            start_ack_q <= 1'b0;
            stop_ack_q  <= 1'b0;
            running_q   <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            sreset_q    <= sreset_d;
            start_ack_q <= start_ack_d;
            stop_ack_q  <= stop_ack_d;
            running_q   <= running_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
        end
    end

    // Act passes straight through only to released groups
    assign d1clk     = act_in & mask_q;
    assign d2clk     = mask_q;
    assign sreset    = sreset_q;
    assign start_ack = start_ack_q;
    assign stop_ack  = stop_ack_q;
    assign running   = running_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tri_lcb_seq.sv
// tb_tri_lcb_seq: self-checking bench for tri_lcb_seq with default parameters.
// Expected outputs come from closed-form timing rules: release times, hold
// times and ack cycles computed from the start/stop pulse cycles.
module tb_tri_lcb_seq;

    localparam int G     = 4;
    localparam int I     = 4;
    localparam int S     = 2;
    localparam int CW    = 4;
    localparam int T_RUN = I + 1 + (G - 1) * S;

    typedef struct packed {
        logic [G-1:0] d2;
        logic [G-1:0] sr;
        logic [G-1:0] d1;
        logic         sa;
        logic         sp;
        logic         run;
        logic         busy;
    } obs_t;

    logic         clk;
    logic         rst_b;
    logic         start_req;
    logic         stop_req;
    logic [G-1:0] act_in;
    logic [G-1:0] d1clk;
    logic [G-1:0] d2clk;
    logic [G-1:0] sreset;
    logic         start_ack;
    logic         stop_ack;
    logic         running;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    tri_lcb_seq #(
        .GROUPS      (G),
        .INIT_CYCLES (I),
        .STAGGER     (S),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start_req (start_req),
        .stop_req  (stop_req),
        .act_in    (act_in),
        .d1clk     (d1clk),
        .d2clk     (d2clk),
        .sreset    (sreset),
        .start_ack (start_ack),
        .stop_ack  (stop_ack),
        .running   (running),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o = {d2clk, sreset, d1clk, start_ack, stop_ack, running, busy};
        return o;
    endfunction

    // Number of groups released after edge c, start at edge 0, stop at edge t
    function automatic int released_at(input int c, input int t);
        int k;
        int th;
        int n;
        n = 0;
        if (c < t) begin
            for (int g = 0; g < G; g++) if (I + 1 + g * S <= c) n++;
            return n;
        end
        k = 0;
        for (int g = 0; g < G; g++) if (I + 1 + g * S < t) k++;
        th = (t > I) ? t : I;
        n  = k;
        for (int j = 0; j < k; j++) if (th + 1 + j * S <= c) n--;
        return n;
    endfunction

    function automatic int ack_at(input int t);
        int k;
        int th;
        k = 0;
        for (int g = 0; g < G; g++) if (I + 1 + g * S < t) k++;
        th = (t > I) ? t : I;
        return (k == 0) ? th + 1 : th + 1 + (k - 1) * S;
    endfunction

    // Start at edge 0, stop at edge t (t >= 1); checks every edge up to ack+3
    task automatic run_seq(input int t, input bit fixed_act, input logic [G-1:0] act_val,
                           input bit extra_starts);
        int           ack;
        int           n;
        obs_t         exp;
        obs_t         got;
        logic [G-1:0] act;
        logic [G-1:0] m;
        ack = ack_at(t);
        for (int c = 0; c <= ack + 3; c++) begin
            @(negedge clk);
            act       = fixed_act ? act_val : G'($urandom_range(0, (1 << G) - 1));
            act_in    = act;
            start_req = (c == 0) || (extra_starts && c >= 1 && c <= ack &&
                                     ($urandom_range(0, 3) == 0));
            stop_req  = (c == t);
            @(posedge clk);
            #1;
            n        = released_at(c, t);
            m        = G'((1 << n) - 1);
            exp.d2   = m;
            exp.sr   = (c >= 1 && c <= I) ? '1 : '0;
            exp.d1   = act & m;
            exp.sa   = (t > T_RUN) && (c == T_RUN);
            exp.sp   = (c == ack);
            exp.run  = (n == G);
            exp.busy = (t > T_RUN) ? ((c < T_RUN) || (c >= t && c < ack)) : (c < ack);
            got      = sample();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL seq stop=%0d cycle=%0d: got d2=%b sr=%b d1=%b sa=%b sp=%b run=%b busy=%b, want d2=%b sr=%b d1=%b sa=%b sp=%b run=%b busy=%b",
                         t, c, got.d2, got.sr, got.d1, got.sa, got.sp, got.run, got.busy,
                         exp.d2, exp.sr, exp.d1, exp.sa, exp.sp, exp.run, exp.busy);
            end
        end
        @(negedge clk);
        start_req = 1'b0;
        stop_req  = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        rst_b     = 1'b0;
        start_req = 1'b0;
        stop_req  = 1'b0;
        act_in    = '1;
        #2;
        got = sample();
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b, want all zero", got);
        end
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %b, want all zero", got);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_sequence();
        run_seq(T_RUN + 3, 1'b1, 4'b1111, 1'b0);
    endtask

    task automatic test_stop_in_init();
        run_seq(2, 1'b1, 4'b1111, 1'b0);
    endtask

    task automatic test_stop_in_release();
        run_seq(8, 1'b1, 4'b1111, 1'b0);
    endtask

    task automatic test_act_gating();
        run_seq(T_RUN + 2, 1'b1, 4'b0101, 1'b0);
    endtask

    task automatic test_boundaries();
        run_seq(I, 1'b0, '0, 1'b1);
        run_seq(I + 1, 1'b0, '0, 1'b1);
        run_seq(T_RUN, 1'b0, '0, 1'b1);
        run_seq(T_RUN + 1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_seq($urandom_range(1, T_RUN + 6), 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_idle_stop();
        @(negedge clk);
        stop_req = 1'b1;
        act_in   = '1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({stop_ack, busy, d2clk, sreset} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL idle_stop_ack: got sp=%b busy=%b d2=%b sr=%b, want sp=1 busy=0 d2=0000 sr=0000",
                     stop_ack, busy, d2clk, sreset);
        end
        @(negedge clk);
        stop_req = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (stop_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stop_pulse: got sp=%b, want 0", stop_ack);
        end
    endtask

    task automatic test_start_stop_same();
        @(negedge clk);
        start_req = 1'b1;
        stop_req  = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({stop_ack, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL start_stop_same_ack: got sp=%b busy=%b, want sp=1 busy=0", stop_ack, busy);
        end
        @(negedge clk);
        start_req = 1'b0;
        stop_req  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({sreset, d2clk, busy, start_ack, stop_ack} !== '0) begin
                n_fail++;
                $display("FAIL start_stop_same_idle cycle=%0d: got sr=%b d2=%b busy=%b sa=%b sp=%b, want all zero",
                         c, sreset, d2clk, busy, start_ack, stop_ack);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            start_req = (c == 0);
            stop_req  = 1'b0;
            act_in    = '1;
            @(posedge clk);
        end
        #3;
        rst_b = 1'b0;
        #1;
        got = sample();
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %b, want all zero", got);
        end
        start_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            got = sample();
            n_tests++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL async_reset_held cycle=%0d: got %b, want all zero", c, got);
            end
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        run_seq(T_RUN + 3, 1'b1, 4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_start_sequence();
        test_stop_in_init();
        test_stop_in_release();
        test_act_gating();
        test_idle_stop();
        test_start_stop_same();
        test_boundaries();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
